hotspot_stencil_pe: RTL and testbench

Compute stage directly downstream of the power delay buffer. Joins one 5-point temperature stencil beat with one aligned power beat and emits the updated centre temperature for one cell. It is a 4-stage stallable fixed-point pipeline with AXI-Stream-style valid/ready on both inputs and the output.

---
 rtl/hotspot_pkg.sv | 22 ++
 rtl/hotspot_fx_mul.sv | 39 +++
 rtl/hotspot_stencil_pe.sv | 128 ++++++++++++
 tb/tb_hotspot_stencil_pe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hotspot_pkg.sv
// Shared constants for the hotspot thermal stencil datapath (Q10.22 temperatures, Q1.31 power).
package hotspot_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INT_WIDTH   = 10;
    localparam int FLOAT_WIDTH = 22;
    localparam int POWER_FRAC  = 31;

    localparam int NUM_LANES = 5;
    localparam int STAGES    = 4;

    localparam int LANE_C = 0;
    localparam int LANE_N = 1;
    localparam int LANE_S = 2;
    localparam int LANE_E = 3;
    localparam int LANE_W = 4;

    localparam logic [DATA_WIDTH-1:0] ONE_Q   = 32'h0040_0000;
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/hotspot_fx_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic shift right (floor),
// then either wrap or saturate to OW bits.
module hotspot_fx_mul #(
    parameter int AW    = 34,
    parameter int BW    = 32,
    parameter int SHIFT = 22,
    parameter int OW    = 36,
    parameter bit SAT   = 1'b0
) (
    input  logic signed [AW-1:0] i_a,
    input  logic signed [BW-1:0] i_b,
    output logic signed [OW-1:0] o_p
);

    localparam int PW = AW + BW;

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_b;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shr;
    logic [PW-OW:0]       w_hi;
    logic                 w_ovf;

    assign w_a    = {{BW{i_a[AW-1]}}, i_a};
    assign w_b    = {{AW{i_b[BW-1]}}, i_b};
    assign w_prod = w_a * w_b;
    assign w_shr  = w_prod >>> SHIFT;

    // Result fits in OW bits only if every bit above the OW sign bit copies it.
    assign w_hi  = w_shr[PW-1:OW-1];
    assign w_ovf = SAT && !((&w_hi) || !(|w_hi));

    always_comb begin
        o_p = w_shr[OW-1:0];
        if (w_ovf)
            o_p = w_shr[PW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end

endmodule

// File: rtl/hotspot_stencil_pe.sv
// Joins a 5-point temperature stencil with its power beat and produces the updated
// centre temperature through a 4-stage stallable pipeline.
module hotspot_stencil_pe
    import hotspot_pkg::*;
#(
    parameter int DATA_WIDTH  = hotspot_pkg::DATA_WIDTH,
    parameter int INT_WIDTH   = hotspot_pkg::INT_WIDTH,
    parameter int FLOAT_WIDTH = hotspot_pkg::FLOAT_WIDTH,
    parameter int POWER_FRAC  = hotspot_pkg::POWER_FRAC
) (
    input  logic                            aclk,
    input  logic                            axi_reset,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] s_axis_temp_data,
    input  logic                            s_axis_temp_last,
    input  logic                            s_axis_temp_valid,
    output logic                            s_axis_temp_ready,
    input  logic [DATA_WIDTH-1:0]           s_axis_power_data,
    input  logic                            s_axis_power_valid,
    output logic                            s_axis_power_ready,
    input  logic [DATA_WIDTH-1:0]           cfg_rx,
    input  logic [DATA_WIDTH-1:0]           cfg_ry,
    input  logic [DATA_WIDTH-1:0]           cfg_rz,
    input  logic [DATA_WIDTH-1:0]           cfg_cap,
    input  logic [DATA_WIDTH-1:0]           cfg_amb,
    output logic [DATA_WIDTH-1:0]           m_axis_data,
    output logic                            m_axis_last,
    output logic                            m_axis_valid,
    input  logic                            m_axis_ready
);

    localparam int DW  = DATA_WIDTH;
    localparam int DX  = DW + 2;
    localparam int SW  = DW + 4;
    localparam int PSH = POWER_FRAC - FLOAT_WIDTH;

    if (INT_WIDTH + FLOAT_WIDTH != DATA_WIDTH) begin : g_bad_fmt
        $error("hotspot_stencil_pe: INT_WIDTH + FLOAT_WIDTH must equal DATA_WIDTH");
    end

    logic              w_ce;
    logic              w_join;
    logic [STAGES:1]   r_vld_pipe;
    logic [STAGES:1]   r_last_pipe;
    logic [DW-1:0]     r4_out;

    assign m_axis_valid       = r_vld_pipe[STAGES];
    assign m_axis_last        = r_last_pipe[STAGES];
    assign m_axis_data        = r4_out;
    assign w_ce               = m_axis_ready | ~m_axis_valid;
    assign s_axis_temp_ready  = w_ce & s_axis_power_valid;
    assign s_axis_power_ready = w_ce & s_axis_temp_valid;
    assign w_join             = w_ce & s_axis_temp_valid & s_axis_power_valid;

    logic [DX-1:0] w_lane [NUM_LANES];
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign w_lane[k] = {{2{s_axis_temp_data[k*DW+DW-1]}}, s_axis_temp_data[k*DW +: DW]};
    end

    logic signed [DX-1:0] w_c, w_n, w_s, w_e, w_w, w_amb;
    assign w_c   = $signed(w_lane[LANE_C]);
    assign w_n   = $signed(w_lane[LANE_N]);
    assign w_s   = $signed(w_lane[LANE_S]);
    assign w_e   = $signed(w_lane[LANE_E]);
    assign w_w   = $signed(w_lane[LANE_W]);
    assign w_amb = {{2{cfg_amb[DW-1]}}, cfg_amb};

    logic signed [DX-1:0] r1_dy, r1_dx, r1_dz;
    logic signed [DW-1:0] r1_p, r1_c, r2_p, r2_c, r3_c;
    logic signed [SW-1:0] r2_py, r2_px, r2_pz, r3_sum;
    logic signed [SW-1:0] w_py, w_px, w_pz, w_p_ext;
    logic signed [DX-1:0] w_delta;
    logic signed [DX:0]   w_sum4;
    logic [DX-DW+1:0]     w_hi4;
    logic [DW-1:0]        w_sat;

    // Stage-2 products wrap to the stage-3 sum width; only the low SW bits matter there.
    hotspot_fx_mul #(.AW(DX), .BW(DW), .SHIFT(FLOAT_WIDTH), .OW(SW), .SAT(1'b0)) u_mul_y (
        .i_a(r1_dy), .i_b(cfg_ry), .o_p(w_py));
    hotspot_fx_mul #(.AW(DX), .BW(DW), .SHIFT(FLOAT_WIDTH), .OW(SW), .SAT(1'b0)) u_mul_x (
        .i_a(r1_dx), .i_b(cfg_rx), .o_p(w_px));
    hotspot_fx_mul #(.AW(DX), .BW(DW), .SHIFT(FLOAT_WIDTH), .OW(SW), .SAT(1'b0)) u_mul_z (
        .i_a(r1_dz), .i_b(cfg_rz), .o_p(w_pz));

    // Clamping delta to DX bits cannot change the final clamp: any delta that large
    // already pushes c + delta past the DW-bit range in the same direction.
    hotspot_fx_mul #(.AW(SW), .BW(DW), .SHIFT(FLOAT_WIDTH), .OW(DX), .SAT(1'b1)) u_mul_cap (
        .i_a(r3_sum), .i_b(cfg_cap), .o_p(w_delta));

    assign w_p_ext = {{(SW-DW){r2_p[DW-1]}}, r2_p};
    assign w_sum4  = {{3{r3_c[DW-1]}}, r3_c} + {w_delta[DX-1], w_delta};
    assign w_hi4   = w_sum4[DX:DW-1];

    always_comb begin
        w_sat = w_sum4[DW-1:0];
        if (!((&w_hi4) || !(|w_hi4)))
            w_sat = w_sum4[DX] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge aclk) begin
        if (w_ce) begin
            r1_dy  <= w_n + w_s - (w_c <<< 1);
            r1_dx  <= w_e + w_w - (w_c <<< 1);
            r1_dz  <= w_amb - w_c;
            r1_p   <= $signed(s_axis_power_data) >>> PSH;
            r1_c   <= w_c[DW-1:0];
            r2_py  <= w_py;
            r2_px  <= w_px;
            r2_pz  <= w_pz;
            r2_p   <= r1_p;
            r2_c   <= r1_c;
            r3_sum <= w_p_ext + r2_py + r2_px + r2_pz;
            r3_c   <= r2_c;
        end
    end

    always_ff @(posedge aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r4_out      <= '0;
        end else if (w_ce) begin
            r_vld_pipe  <= {r_vld_pipe[STAGES-1:1], w_join};
            r_last_pipe <= {r_last_pipe[STAGES-1:1], w_join & s_axis_temp_last};
            r4_out      <= w_sat;
        end
    end

endmodule

// File: tb/tb_hotspot_stencil_pe.sv
// Bench for hotspot_stencil_pe: directed vector table, join/reset sequences and
// randomized bursts scored against an arithmetic reference model.
module tb_hotspot_stencil_pe;

    logic         aclk;
    logic         axi_reset;
    logic [159:0] s_axis_temp_data;
    logic         s_axis_temp_last;
    logic         s_axis_temp_valid;
    logic         s_axis_temp_ready;
    logic [31:0]  s_axis_power_data;
    logic         s_axis_power_valid;
    logic         s_axis_power_ready;
    logic [31:0]  cfg_rx, cfg_ry, cfg_rz, cfg_cap, cfg_amb;
    logic [31:0]  m_axis_data;
    logic         m_axis_last;
    logic         m_axis_valid;
    logic         m_axis_ready;

    hotspot_stencil_pe dut (
        .aclk(aclk), .axi_reset(axi_reset),
        .s_axis_temp_data(s_axis_temp_data), .s_axis_temp_last(s_axis_temp_last),
        .s_axis_temp_valid(s_axis_temp_valid), .s_axis_temp_ready(s_axis_temp_ready),
        .s_axis_power_data(s_axis_power_data), .s_axis_power_valid(s_axis_power_valid),
        .s_axis_power_ready(s_axis_power_ready),
        .cfg_rx(cfg_rx), .cfg_ry(cfg_ry), .cfg_rz(cfg_rz), .cfg_cap(cfg_cap), .cfg_amb(cfg_amb),
        .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
        .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [159:0] t;
        logic [31:0]  pw, rx, ry, rz, cap, amb;
        logic         lst;
        logic [31:0]  exp;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    exp_t q[$];
    logic stall_prev = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [159:0] pack5(input logic [31:0] c, n, s, e, w);
        return {w, e, s, n, c};
    endfunction

    // Plain wide-integer evaluation of the update rule.
    function automatic logic [31:0] model(input logic [159:0] t, input logic [31:0] pw,
                                          input logic [31:0] rx, ry, rz, cap, amb);
        logic signed [127:0] c, n, s, e, w, a, dy, dx, dz, p, sum, delta, o;
        logic signed [35:0]  s36;
        c = $signed(t[31:0]);   n = $signed(t[63:32]);  s = $signed(t[95:64]);
        e = $signed(t[127:96]); w = $signed(t[159:128]); a = $signed(amb);
        dy = n + s - 2 * c;
        dx = e + w - 2 * c;
        dz = a - c;
        p  = $signed(pw);
        p  = p >>> 9;
        sum = p + ((dy * $signed(ry)) >>> 22) + ((dx * $signed(rx)) >>> 22)
                + ((dz * $signed(rz)) >>> 22);
        s36 = sum[35:0];
        sum = s36;
        delta = (sum * $signed(cap)) >>> 22;
        o = c + delta;
        if (o > 128'sd2147483647) return 32'h7FFF_FFFF;
        if (o < -128'sd2147483648) return 32'h8000_0000;
        return o[31:0];
    endfunction

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        if (axi_reset) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", m_axis_valid, 1);
                chk("hold_data", m_axis_data, prev_d);
                chk("hold_last", m_axis_last, prev_l);
            end
            if (m_axis_valid && !m_axis_ready)
                chk("stall_noaccept", {s_axis_temp_ready, s_axis_power_ready}, 0);
            if ((s_axis_temp_valid && s_axis_temp_ready) || (s_axis_power_valid && s_axis_power_ready)) begin
                chk("join_pair", s_axis_temp_valid && s_axis_temp_ready, s_axis_power_valid && s_axis_power_ready);
                if (s_axis_temp_valid && s_axis_temp_ready)
                    q.push_back('{model(s_axis_temp_data, s_axis_power_data, cfg_rx, cfg_ry, cfg_rz,
                                        cfg_cap, cfg_amb), s_axis_temp_last});
            end
            if (m_axis_valid && m_axis_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got output %0h expected none", m_axis_data);
                end else begin
                    chk("sb_data", m_axis_data, q[0].d);
                    chk("sb_last", m_axis_last, q[0].l);
                    void'(q.pop_front());
                end
            end
            stall_prev <= m_axis_valid && !m_axis_ready;
            prev_d     <= m_axis_data;
            prev_l     <= m_axis_last;
        end
    end

    task automatic set_cfg(input vec_t v);
        cfg_rx = v.rx; cfg_ry = v.ry; cfg_rz = v.rz; cfg_cap = v.cap; cfg_amb = v.amb;
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        int cnt;
        set_cfg(v);
        s_axis_temp_data = v.t; s_axis_power_data = v.pw; s_axis_temp_last = v.lst;
        s_axis_temp_valid = 1'b1; s_axis_power_valid = 1'b1; m_axis_ready = 1'b1;
        #1;
        chk({nm, "_rdy"}, {s_axis_temp_ready, s_axis_power_ready}, 2'b11);
        tick();
        s_axis_temp_valid = 1'b0; s_axis_power_valid = 1'b0; s_axis_temp_last = 1'b0;
        cnt = 1;
        while (!m_axis_valid && cnt < 12) begin
            tick();
            cnt++;
        end
        chk({nm, "_lat"}, cnt, 4);
        chk({nm, "_data"}, m_axis_data, v.exp);
        chk({nm, "_last"}, m_axis_last, v.lst);
        tick();
    endtask

    vec_t         tbl[6];
    logic [159:0] bt[40];
    logic [31:0]  bp[40];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, guard, n0;
        logic acc;

        tbl[0] = '{pack5(32'h400000, 32'h400000, 32'h400000, 32'h400000, 32'h400000), 32'h0,
                   32'h200000, 32'h200000, 32'h200000, 32'h200000, 32'h400000, 1'b0, 32'h0040_0000};
        tbl[1] = '{pack5(32'h400000, 32'h400000, 32'h400000, 32'h400000, 32'h400000), 32'h4000_0000,
                   32'h200000, 32'h200000, 32'h200000, 32'h200000, 32'h400000, 1'b1, 32'h0050_0000};
        tbl[2] = '{pack5(32'h7FF00000, 32'h7FF00000, 32'h7FF00000, 32'h7FF00000, 32'h7FF00000), 32'h7FFF_FFFF,
                   32'h200000, 32'h200000, 32'h200000, 32'h7FFF_FFFF, 32'h7FF00000, 1'b0, 32'h7FFF_FFFF};
        tbl[3] = '{pack5(32'h80100000, 32'h80100000, 32'h80100000, 32'h80100000, 32'h80100000), 32'h8000_0000,
                   32'h200000, 32'h200000, 32'h200000, 32'h7FFF_FFFF, 32'h80100000, 1'b1, 32'h8000_0000};
        tbl[4] = '{pack5(32'h400000, 32'h800000, 32'h400000, 32'h400000, 32'h400000), 32'h0,
                   32'h400000, 32'h400000, 32'h200000, 32'h400000, 32'h0, 1'b0, 32'h0060_0000};
        tbl[5] = '{pack5(32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0), 32'h0,
                   32'h0, 32'h200000, 32'h0, 32'h400000, 32'h0, 1'b1, 32'hFFFF_FFFF};

        axi_reset = 1'b1;
        s_axis_temp_data = '0; s_axis_temp_last = 1'b0; s_axis_temp_valid = 1'b0;
        s_axis_power_data = '0; s_axis_power_valid = 1'b0; m_axis_ready = 1'b0;
        set_cfg(tbl[0]);
        tick(); tick();
        chk("rst_valid", m_axis_valid, 0);
        chk("rst_last", m_axis_last, 0);
        chk("rst_data", m_axis_data, 0);
        axi_reset = 1'b0;
        tick();
        chk("idle_ready", {s_axis_temp_ready, s_axis_power_ready}, 0);

        for (int k = 0; k < 6; k++) apply_vec(tbl[k], $sformatf("vec%0d", k));

        // Temp valid alone must wait for power.
        set_cfg(tbl[1]);
        s_axis_temp_data = tbl[1].t; s_axis_power_data = tbl[1].pw; s_axis_temp_last = 1'b1;
        s_axis_temp_valid = 1'b1; m_axis_ready = 1'b1;
        n0 = n_out;
        for (int cyc = 0; cyc < 3; cyc++) begin
            #1 chk($sformatf("skew_noready%0d", cyc), s_axis_temp_ready, 0);
            tick();
        end
        s_axis_power_valid = 1'b1;
        #1 chk("skew_ready3", {s_axis_temp_ready, s_axis_power_ready}, 2'b11);
        tick();
        s_axis_temp_valid = 1'b0; s_axis_power_valid = 1'b0; s_axis_temp_last = 1'b0;
        for (int cyc = 4; cyc <= 10; cyc++) begin
            chk($sformatf("skew_out%0d", cyc), m_axis_valid, (cyc == 7));
            tick();
        end
        chk("skew_count", n_out - n0, 1);

        // Reset with the pipeline full and stalled.
        set_cfg(tbl[0]);
        m_axis_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_axis_temp_data = tbl[k].t; s_axis_power_data = tbl[k].pw;
            s_axis_temp_valid = 1'b1; s_axis_power_valid = 1'b1;
            tick();
        end
        s_axis_temp_valid = 1'b0; s_axis_power_valid = 1'b0;
        chk("prefill_valid", m_axis_valid, 1);
        #3 axi_reset = 1'b1;
        #1;
        chk("async_rst_valid", m_axis_valid, 0);
        chk("async_rst_last", m_axis_last, 0);
        chk("async_rst_data", m_axis_data, 0);
        q.delete();
        tick(); tick();
        axi_reset = 1'b0;
        m_axis_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("post_rst_idle", m_axis_valid, 0);
            tick();
        end
        n0 = n_out;
        apply_vec(tbl[1], "post_rst");
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_quiet", m_axis_valid, 0);
            tick();
        end
        chk("post_rst_count", n_out - n0, 1);

        // Burst A: 16 back-to-back full-range beats under random backpressure.
        cfg_rx = $urandom; cfg_ry = $urandom; cfg_rz = $urandom; cfg_cap = $urandom; cfg_amb = $urandom;
        for (int k = 0; k < 16; k++) begin
            bt[k] = {$urandom, $urandom, $urandom, $urandom, $urandom};
            bp[k] = $urandom;
        end
        n0 = n_out; i = 0; guard = 0;
        while (i < 16 && guard < 400) begin
            s_axis_temp_data = bt[i]; s_axis_power_data = bp[i]; s_axis_temp_last = (i == 15);
            s_axis_temp_valid = 1'b1; s_axis_power_valid = 1'b1;
            m_axis_ready = 1'($urandom_range(0, 1));
            @(negedge aclk);
            acc = s_axis_temp_valid && s_axis_temp_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        chk("burstA_accepted", i, 16);
        s_axis_temp_valid = 1'b0; s_axis_power_valid = 1'b0; s_axis_temp_last = 1'b0;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            m_axis_ready = (guard > 100) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        chk("burstA_outputs", n_out - n0, 16);

        // Burst B: moderate values, independent valids on each input.
        cfg_rx = $urandom_range(0, 32'h0040_0000); cfg_ry = $urandom_range(0, 32'h0040_0000);
        cfg_rz = $urandom_range(0, 32'h0040_0000); cfg_cap = $urandom_range(0, 32'h0080_0000);
        cfg_amb = $urandom_range(0, 32'h0800_0000) - 32'h0400_0000;
        for (int k = 0; k < 40; k++) begin
            for (int l = 0; l < 5; l++)
                bt[k][l*32 +: 32] = $urandom_range(0, 32'h0800_0000) - 32'h0400_0000;
            bp[k] = $urandom;
        end
        n0 = n_out; i = 0; guard = 0;
        while (i < 40 && guard < 1000) begin
            s_axis_temp_data = bt[i]; s_axis_power_data = bp[i]; s_axis_temp_last = (i % 7 == 6);
            s_axis_temp_valid  = ($urandom_range(0, 3) != 0);
            s_axis_power_valid = ($urandom_range(0, 3) != 0);
            m_axis_ready = ($urandom_range(0, 3) != 0);
            @(negedge aclk);
            acc = s_axis_temp_valid && s_axis_temp_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        chk("burstB_accepted", i, 40);
        s_axis_temp_valid = 1'b0; s_axis_power_valid = 1'b0; s_axis_temp_last = 1'b0;
        m_axis_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        chk("burstB_outputs", n_out - n0, 40);
        chk("sb_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
